conv_tap_sequencer: RTL and testbench

//  Parametrised successor to the conv loop iterator. Walks out_ch > out_row > out_col > ker_row > ker_col > in_ch
//  (in_ch innermost) and issues one input-tap address per beat to the MAC/accumulator over a valid/ready handshake.

---
 rtl/conv_tap_sequencer_pkg.sv | 21 ++
 rtl/conv_tap_sequencer_wrap_counter.sv | 47 ++++
 rtl/conv_tap_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_conv_tap_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_tap_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_tap_sequencer_pkg
// Description : Shared constants for the convolution tap sequencer: FSM state
//               encodings and the default counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_tap_sequencer_pkg;

    // Byte width, used as the default counter/index width.
    localparam int c_BYTE          = 8;
    localparam int c_CNT_W_DEFAULT = c_BYTE;

    // Sequencer states
    localparam int         c_STATE_W  = 2;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

endpackage : conv_tap_sequencer_pkg
`default_nettype wire

// File: rtl/conv_tap_sequencer_wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : wrap_counter
// Description : One loop level of the tap iterator. Counts 0..LIMIT-1 on inc
//               and wraps to 0; wrap is the carry into the next outer level.
//               limit_sel forces an effective limit of 1 (level collapsed).
// Ports       : clk, reset (async, active-low), inc, clr (sync clear),
//               limit_sel, value [WIDTH-1:0], wrap
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic             limit_sel,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] w_last;
    logic             w_at_last;

    // A collapsed level has a single value (0), so it wraps on every inc.
    assign w_last    = limit_sel ? '0 : c_LAST;
    assign w_at_last = (r_value == w_last);
    assign wrap      = inc && w_at_last;
    assign value     = r_value;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc) begin
            r_value <= w_at_last ? '0 : r_value + WIDTH'(1);
        end
    end

endmodule : wrap_counter
`default_nettype wire

// File: rtl/conv_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv_tap_sequencer
// Description : Convolution tap iterator. Walks out_ch > out_row > out_col >
//               ker_row > ker_col > in_ch and presents one input-tap address
//               per beat over valid/ready. Padding taps are skipped at one per
//               cycle without a beat. Supports a depthwise mode (in_ch follows
//               out_ch), abort, and a start/busy/done handshake.
// Ports       : clk, reset (async, active-low), start, depthwise, abort,
//               busy, done, tap_valid/tap_ready/tap_first, in_row/in_col
//               (signed), in_ch, ker_row, ker_col, out_ch, out_row, out_col,
//               pix_save, save_ch, save_row, save_col
// Revision    : 1.0 - initial release
// ============================================================================
module conv_tap_sequencer
    import conv_tap_sequencer_pkg::*;
#(
    parameter int CNT_W   = c_CNT_W_DEFAULT,
    parameter int IMG_H   = 32,
    parameter int IMG_W   = 32,
    parameter int OUT_H   = 32,
    parameter int OUT_W   = 32,
    parameter int KER_H   = 5,
    parameter int KER_W   = 5,
    parameter int IN_CH   = 3,
    parameter int OUT_CH  = 32,
    parameter int STRIDE  = 1,
    parameter int PADDING = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    depthwise,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    tap_valid,
    input  logic                    tap_ready,
    output logic                    tap_first,
    output logic signed [CNT_W+1:0] in_row,
    output logic signed [CNT_W+1:0] in_col,
    output logic [CNT_W-1:0]        in_ch,
    output logic [CNT_W-1:0]        ker_row,
    output logic [CNT_W-1:0]        ker_col,
    output logic [CNT_W-1:0]        out_ch,
    output logic [CNT_W-1:0]        out_row,
    output logic [CNT_W-1:0]        out_col,
    output logic                    pix_save,
    output logic [CNT_W-1:0]        save_ch,
    output logic [CNT_W-1:0]        save_row,
    output logic [CNT_W-1:0]        save_col
);

    localparam int AW = CNT_W + 2;

    localparam logic [AW-1:0] c_STRIDE_X = AW'(STRIDE);
    localparam logic [AW-1:0] c_PAD_X    = AW'(PADDING);
    localparam logic [AW-1:0] c_IMG_H_X  = AW'(IMG_H);
    localparam logic [AW-1:0] c_IMG_W_X  = AW'(IMG_W);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;
    logic                 r_depthwise;
    logic                 r_first_armed;
    logic                 r_pix_save;
    logic [CNT_W-1:0]     r_save_ch;
    logic [CNT_W-1:0]     r_save_row;
    logic [CNT_W-1:0]     r_save_col;

    logic [CNT_W-1:0] w_cnt_in_ch;
    logic [CNT_W-1:0] w_ker_row;
    logic [CNT_W-1:0] w_ker_col;
    logic [CNT_W-1:0] w_out_ch;
    logic [CNT_W-1:0] w_out_row;
    logic [CNT_W-1:0] w_out_col;

    logic w_wrap_in_ch;
    logic w_wrap_ker_col;
    logic w_wrap_ker_row;
    logic w_wrap_out_col;
    logic w_wrap_out_row;
    logic w_wrap_out_ch;

    logic [AW-1:0] w_in_row;
    logic [AW-1:0] w_in_col;
    logic          w_in_bounds;
    logic          w_run;
    logic          w_retire;
    logic          w_accept;
    logic          w_start_ok;

    assign w_run      = (r_state == c_ST_RUN);
    assign w_start_ok = (r_state == c_ST_IDLE) && start && !abort;

    // ------------------------------------------------------------------
    // Input coordinate and padding check. Sums are formed unsigned in AW
    // bits and then read as two's complement; the parameter constraint
    // keeps the largest positive sum below 2^(CNT_W+1).
    // ------------------------------------------------------------------
    assign w_in_row = c_STRIDE_X * {2'b00, w_out_row} + {2'b00, w_ker_row} - c_PAD_X;
    assign w_in_col = c_STRIDE_X * {2'b00, w_out_col} + {2'b00, w_ker_col} - c_PAD_X;

    assign w_in_bounds = ($signed(w_in_row) >= $signed(AW'(0)))
                      && ($signed(w_in_col) >= $signed(AW'(0)))
                      && ($signed(w_in_row) <  $signed(c_IMG_H_X))
                      && ($signed(w_in_col) <  $signed(c_IMG_W_X));

    // A tap retires either when its beat is accepted or, for a padding
    // tap, unconditionally (skip costs one cycle, produces no beat).
    assign w_accept = tap_valid && tap_ready;
    assign w_retire = w_run && (!w_in_bounds || tap_ready);

    // ------------------------------------------------------------------
    // Loop nest: in_ch innermost, chained by wrap carries.
    // ------------------------------------------------------------------
    wrap_counter #(.WIDTH(CNT_W), .LIMIT(IN_CH)) u_cnt_in_ch (
        .clk(clk), .reset(reset), .inc(w_retire), .clr(abort),
        .limit_sel(r_depthwise), .value(w_cnt_in_ch), .wrap(w_wrap_in_ch)
    );
    wrap_counter #(.WIDTH(CNT_W), .LIMIT(KER_W)) u_cnt_ker_col (
        .clk(clk), .reset(reset), .inc(w_wrap_in_ch), .clr(abort),
        .limit_sel(1'b0), .value(w_ker_col), .wrap(w_wrap_ker_col)
    );
    wrap_counter #(.WIDTH(CNT_W), .LIMIT(KER_H)) u_cnt_ker_row (
        .clk(clk), .reset(reset), .inc(w_wrap_ker_col), .clr(abort),
        .limit_sel(1'b0), .value(w_ker_row), .wrap(w_wrap_ker_row)
    );
    wrap_counter #(.WIDTH(CNT_W), .LIMIT(OUT_W)) u_cnt_out_col (
        .clk(clk), .reset(reset), .inc(w_wrap_ker_row), .clr(abort),
        .limit_sel(1'b0), .value(w_out_col), .wrap(w_wrap_out_col)
    );
    wrap_counter #(.WIDTH(CNT_W), .LIMIT(OUT_H)) u_cnt_out_row (
        .clk(clk), .reset(reset), .inc(w_wrap_out_col), .clr(abort),
        .limit_sel(1'b0), .value(w_out_row), .wrap(w_wrap_out_row)
    );
    wrap_counter #(.WIDTH(CNT_W), .LIMIT(OUT_CH)) u_cnt_out_ch (
        .clk(clk), .reset(reset), .inc(w_wrap_out_row), .clr(abort),
        .limit_sel(1'b0), .value(w_out_ch), .wrap(w_wrap_out_ch)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: if (start)         w_state_next = c_ST_RUN;
                c_ST_RUN:  if (w_wrap_out_ch) w_state_next = c_ST_DONE;
                c_ST_DONE:                    w_state_next = c_ST_IDLE;
                default:                      w_state_next = c_ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Mode latch, first-beat flag and pixel-save bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_depthwise   <= 1'b0;
            r_first_armed <= 1'b0;
            r_pix_save    <= 1'b0;
            r_save_ch     <= '0;
            r_save_row    <= '0;
            r_save_col    <= '0;
        end else begin
            if (w_start_ok) begin
                r_depthwise <= depthwise;
            end

            // Re-arm on pixel change takes priority over clearing, so a
            // pixel whose last tap is an accepted beat still arms the next.
            if (abort) begin
                r_first_armed <= 1'b0;
            end else if (w_start_ok || w_wrap_ker_row) begin
                r_first_armed <= 1'b1;
            end else if (w_accept) begin
                r_first_armed <= 1'b0;
            end

            r_pix_save <= w_wrap_ker_row && !abort;
            if (w_wrap_ker_row && !abort) begin
                r_save_ch  <= w_out_ch;
                r_save_row <= w_out_row;
                r_save_col <= w_out_col;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy      = (r_state != c_ST_IDLE);
    assign done      = (r_state == c_ST_DONE);
    assign tap_valid = w_run && w_in_bounds;
    assign tap_first = tap_valid && r_first_armed;
    assign in_row    = $signed(w_in_row);
    assign in_col    = $signed(w_in_col);
    assign in_ch     = r_depthwise ? w_out_ch : w_cnt_in_ch;
    assign ker_row   = w_ker_row;
    assign ker_col   = w_ker_col;
    assign out_ch    = w_out_ch;
    assign out_row   = w_out_row;
    assign out_col   = w_out_col;
    assign pix_save  = r_pix_save;
    assign save_ch   = r_save_ch;
    assign save_row  = r_save_row;
    assign save_col  = r_save_col;

endmodule : conv_tap_sequencer
`default_nettype wire

// File: tb/tb_conv_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_tap_sequencer
// Description : Scoreboard bench for conv_tap_sequencer (4x4 image, 3x3
//               kernel, pad 1, 2 in / 2 out channels). A loop model pushes
//               the expected beats and pixel saves at start; a negedge
//               monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_tap_sequencer;

    localparam int CNT_W = 8;
    localparam int IMG   = 4;
    localparam int KER   = 3;
    localparam int PAD   = 1;
    localparam int NCH   = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              depthwise = 1'b0;
    logic              abort = 1'b0;
    logic              tap_ready = 1'b1;
    logic              busy, done, tap_valid, tap_first, pix_save;
    logic signed [9:0] in_row, in_col;
    logic [7:0]        in_ch, ker_row, ker_col, out_ch, out_row, out_col;
    logic [7:0]        save_ch, save_row, save_col;

    conv_tap_sequencer #(
        .CNT_W(CNT_W), .IMG_H(IMG), .IMG_W(IMG), .OUT_H(IMG), .OUT_W(IMG),
        .KER_H(KER), .KER_W(KER), .IN_CH(NCH), .OUT_CH(NCH),
        .STRIDE(1), .PADDING(PAD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .depthwise(depthwise),
        .abort(abort), .busy(busy), .done(done), .tap_valid(tap_valid),
        .tap_ready(tap_ready), .tap_first(tap_first), .in_row(in_row),
        .in_col(in_col), .in_ch(in_ch), .ker_row(ker_row), .ker_col(ker_col),
        .out_ch(out_ch), .out_row(out_row), .out_col(out_col),
        .pix_save(pix_save), .save_ch(save_ch), .save_row(save_row),
        .save_col(save_col)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fails  = 0;
    int           n_beats  = 0;
    int           n_saves  = 0;
    int           n_done   = 0;
    bit           dw_mode  = 1'b0;
    logic [127:0] exp_beats[$];
    logic [23:0]  exp_saves[$];

    task automatic check_val(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] beat_word(
        input logic [9:0] ir, input logic [9:0] ic, input logic [7:0] ich,
        input logic [7:0] kr, input logic [7:0] kc, input logic [7:0] oc,
        input logic [7:0] orow, input logic [7:0] ocol, input logic f);
        return {59'd0, ir, ic, ich, kr, kc, oc, orow, ocol, f};
    endfunction

    // Reference loop nest: expected beats and pixel saves for one pass.
    task automatic push_pass(input bit dw);
        int ir, icl, nic;
        bit first;
        nic = dw ? 1 : NCH;
        for (int oc = 0; oc < NCH; oc++)
            for (int orow = 0; orow < IMG; orow++)
                for (int ocol = 0; ocol < IMG; ocol++) begin
                    first = 1'b1;
                    for (int kr = 0; kr < KER; kr++)
                        for (int kc = 0; kc < KER; kc++)
                            for (int ic = 0; ic < nic; ic++) begin
                                ir  = orow + kr - PAD;
                                icl = ocol + kc - PAD;
                                if (ir >= 0 && icl >= 0 && ir < IMG && icl < IMG) begin
                                    exp_beats.push_back(beat_word(10'(ir), 10'(icl),
                                        8'(dw ? oc : ic), 8'(kr), 8'(kc), 8'(oc),
                                        8'(orow), 8'(ocol), first));
                                    first = 1'b0;
                                end
                            end
                    exp_saves.push_back({8'(oc), 8'(orow), 8'(ocol)});
                end
    endtask

    function automatic logic [127:0] cur_beat();
        return beat_word(in_row, in_col, in_ch, ker_row, ker_col,
                         out_ch, out_row, out_col, tap_first);
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            if (tap_valid && tap_ready) begin
                n_beats++;
                check_val("beat_q_nonempty", 128'(exp_beats.size() != 0), 128'd1);
                if (exp_beats.size() != 0)
                    check_val("beat", cur_beat(), exp_beats.pop_front());
                if (dw_mode)
                    check_val("dw_in_ch", 128'(in_ch), 128'(out_ch));
            end
            if (pix_save) begin
                n_saves++;
                check_val("save_q_nonempty", 128'(exp_saves.size() != 0), 128'd1);
                if (exp_saves.size() != 0)
                    check_val("save_coord", 128'({save_ch, save_row, save_col}),
                              128'(exp_saves.pop_front()));
            end
            if (done) n_done++;
        end
    end

    task automatic start_pass(input bit dw);
        @(posedge clk); #1;
        n_beats = 0; n_saves = 0; n_done = 0;
        exp_beats.delete(); exp_saves.delete();
        push_pass(dw);
        dw_mode   = dw;
        start     = 1'b1;
        depthwise = dw;
        @(posedge clk); #1;
        start     = 1'b0;
        depthwise = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic finish_pass_checks(input string tag, input int beats);
        bit seen;
        wait_done(3000, seen);
        check_val({tag, "_done_seen"}, 128'(seen), 128'd1);
        check_val({tag, "_save_with_done"}, 128'(pix_save), 128'd1);
        @(negedge clk);
        check_val({tag, "_busy_drop"}, 128'(busy), 128'd0);
        check_val({tag, "_beats"}, 128'(n_beats), 128'(beats));
        check_val({tag, "_saves"}, 128'(n_saves), 128'd32);
        check_val({tag, "_done_cnt"}, 128'(n_done), 128'd1);
        check_val({tag, "_q_empty"}, 128'(exp_beats.size() + exp_saves.size()), 128'd0);
    endtask

    initial begin
        logic [127:0] snap;
        bit           stalled, seen;

        // Reset state
        #12;
        check_val("rst_flags", 128'({busy, done, tap_valid, pix_save, tap_first}), 128'd0);
        check_val("rst_save", 128'({save_ch, save_row, save_col}), 128'd0);
        check_val("rst_idx", 128'({in_ch, ker_row, ker_col, out_ch, out_row, out_col}), 128'd0);
        #11 reset = 1'b1;

        // Standard pass, always ready
        tap_ready = 1'b1;
        start_pass(1'b0);
        @(negedge clk);
        check_val("busy_after_start", 128'(busy), 128'd1);
        finish_pass_checks("std", 400);

        // Depthwise pass
        start_pass(1'b1);
        finish_pass_checks("dw", 200);

        // Random backpressure with one forced 5-cycle stall mid-pixel
        start_pass(1'b0);
        stalled = 1'b0;
        for (int c = 0; c < 6000 && n_done == 0; c++) begin
            @(posedge clk); #1;
            if (!stalled && n_beats >= 13) begin
                stalled   = 1'b1;
                tap_ready = 1'b0;
                seen      = 1'b0;
                for (int w = 0; w < 20 && !seen; w++) begin
                    @(negedge clk);
                    seen = tap_valid;
                end
                check_val("stall_valid_seen", 128'(seen), 128'd1);
                snap = cur_beat();
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check_val("stall_valid", 128'(tap_valid), 128'd1);
                    check_val("stall_hold", cur_beat(), snap);
                end
                @(posedge clk); #1;
            end
            tap_ready = ($urandom_range(0, 3) != 0);
        end
        tap_ready = 1'b1;
        check_val("bp_stalled", 128'(stalled), 128'd1);
        check_val("bp_done_cnt", 128'(n_done), 128'd1);
        check_val("bp_beats", 128'(n_beats), 128'd400);
        check_val("bp_saves", 128'(n_saves), 128'd32);
        check_val("bp_q_empty", 128'(exp_beats.size() + exp_saves.size()), 128'd0);
        repeat (3) @(posedge clk);

        // Start while busy is ignored, then abort
        start_pass(1'b0);
        repeat (30) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check_val("abort_flags", 128'({busy, tap_valid, pix_save, done}), 128'd0);
        check_val("abort_idx", 128'({in_ch, ker_row, ker_col, out_ch, out_row, out_col}), 128'd0);
        repeat (10) @(negedge clk);
        check_val("abort_no_done", 128'(n_done), 128'd0);
        check_val("abort_idle", 128'(busy), 128'd0);
        exp_beats.delete(); exp_saves.delete();

        // Asynchronous reset between edges mid-pass, then a clean restart
        start_pass(1'b0);
        repeat (40) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_val("arst_flags", 128'({busy, tap_valid, pix_save}), 128'd0);
        check_val("arst_idx", 128'({out_ch, out_row, out_col, ker_row, ker_col}), 128'd0);
        exp_beats.delete(); exp_saves.delete();
        @(negedge clk); #2 reset = 1'b1;
        start_pass(1'b0);
        finish_pass_checks("restart", 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_conv_tap_sequencer
`default_nettype wire
